// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC endpoint transmitter.
//   tx_state_t       : packet framing FSM state (head / body flit expected)
//   ERR_CREDIT_OVF   : err_out bit, credit returned while the counter was full
//   ERR_PKT_TRUNC    : err_out bit, packet cut at the maximum flit count
package noc_pkg;

  typedef enum logic {
    TX_HEAD = 1'b0,
    TX_BODY = 1'b1
  } tx_state_t;

  localparam int unsigned ERR_W          = 2;
  localparam int unsigned ERR_CREDIT_OVF = 0;
  localparam int unsigned ERR_PKT_TRUNC  = 1;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter tracking free slots in the downstream router input buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   credit_in  : one-cycle pulse, one slot freed by the router
//   consume    : one flit sent this cycle (never asserted when count is 0)
//   count      : current credits, resets to DEPTH
//   overflow   : sticky flag, credit returned while already at DEPTH
module noc_credit_counter #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          credit_in,
  input  logic          consume,
  output logic [CW-1:0] count,
  output logic          overflow
);

  // Simultaneous credit and consume cancel; an excess credit saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= CW'(DEPTH);
      overflow <= 1'b0;
    end else if (credit_in && !consume) begin
      if (count == CW'(DEPTH)) overflow <= 1'b1;
      else                     count    <= count + CW'(1);
    end else if (!credit_in && consume) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/noc_endpoint_tx.sv
// NoC endpoint transmitter: frames upstream flits into packets and sends them
// to the router under credit-based flow control.
// Optional statistics counters enabled by macro NOC_ENDPOINT_TX_STATS_EN.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : upstream handshake (in_ready is combinational)
//   in_data/in_dest/in_last    : upstream flit, destination (head only), last
//   data_out/dest_out          : flit payload and packet destination to router
//   is_tail_out/send_out       : tail marker and per-flit send pulse
//   credit_in                  : router buffer slot returned
//   err_out                    : sticky {truncated, credit overflow}
//   pkt_count/flit_count       : packets/flits sent (0 without statistics)
module noc_endpoint_tx
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH        = 256,
  parameter int unsigned DEST_WIDTH        = 3,
  parameter int unsigned FLIT_BUFFER_DEPTH = 2,
  parameter int unsigned MAX_PACKET_FLITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_last,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [ERR_W-1:0]      err_out,
  output logic [31:0]           pkt_count,
  output logic [31:0]           flit_count
);

  localparam int unsigned CW  = $clog2(FLIT_BUFFER_DEPTH) + 1;
  localparam int unsigned FCW = $clog2(MAX_PACKET_FLITS + 1);

  tx_state_t             state;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [FCW-1:0]        pkt_flits;
  logic                  err_trunc;
  logic [CW-1:0]         credits;
  logic                  credit_ovf;
  logic                  accept;
  logic                  forced_tail;
  logic [DEST_WIDTH-1:0] cur_dest;

  noc_credit_counter #(.DEPTH(FLIT_BUFFER_DEPTH)) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .credit_in(credit_in),
    .consume  (accept),
    .count    (credits),
    .overflow (credit_ovf)
  );

  assign in_ready = (credits != CW'(0)) & rst_n;
  assign accept   = in_valid & in_ready;

  // The last allowed flit of an unterminated packet becomes a forced tail.
  assign forced_tail = !in_last && (pkt_flits == FCW'(MAX_PACKET_FLITS - 1));
  assign cur_dest    = (state == TX_HEAD) ? in_dest : dest_q;

  always_comb begin
    err_out                 = '0;
    err_out[ERR_CREDIT_OVF] = credit_ovf;
    err_out[ERR_PKT_TRUNC]  = err_trunc;
  end

  // Packet framing FSM with registered router-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= TX_HEAD;
      dest_q      <= '0;
      pkt_flits   <= '0;
      err_trunc   <= 1'b0;
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= accept;
      if (accept) begin
        data_out    <= in_data;
        dest_out    <= cur_dest;
        dest_q      <= cur_dest;
        is_tail_out <= in_last | forced_tail;
        if (forced_tail) err_trunc <= 1'b1;
        if (in_last || forced_tail) begin
          state     <= TX_HEAD;
          pkt_flits <= '0;
        end else begin
          state     <= TX_BODY;
          pkt_flits <= pkt_flits + FCW'(1);
        end
      end
    end
  end

`ifdef NOC_ENDPOINT_TX_STATS_EN
  // Statistics follow the send pulses and wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (send_out) begin
      flit_count <= flit_count + 32'd1;
      if (is_tail_out) pkt_count <= pkt_count + 32'd1;
    end
  end
`else
  assign pkt_count  = '0;
  assign flit_count = '0;
`endif

endmodule

// File: tb/tb_noc_endpoint_tx.sv
module tb_noc_endpoint_tx;

  localparam int unsigned FW = 32;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_last;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [1:0]    err_out;
  logic [31:0]   pkt_count;
  logic [31:0]   flit_count;

  int checks   = 0;
  int failures = 0;

`ifdef NOC_ENDPOINT_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  noc_endpoint_tx #(
    .FLIT_WIDTH       (FW),
    .DEST_WIDTH       (DW),
    .FLIT_BUFFER_DEPTH(2),
    .MAX_PACKET_FLITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_last    (in_last),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .is_tail_out(is_tail_out),
    .send_out   (send_out),
    .credit_in  (credit_in),
    .err_out    (err_out),
    .pkt_count  (pkt_count),
    .flit_count (flit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] d, input logic [DW-1:0] de,
                       input logic l, input logic c);
    in_valid  = v;
    in_data   = d;
    in_dest   = de;
    in_last   = l;
    credit_in = c;
  endtask

  task automatic chk_flit(input string tag, input logic [FW-1:0] d, input logic [DW-1:0] de,
                          input logic t);
    chk({tag, "_send"}, 64'(send_out), 64'd1);
    chk({tag, "_data"}, 64'(data_out), 64'(d));
    chk({tag, "_dest"}, 64'(dest_out), 64'(de));
    chk({tag, "_tail"}, 64'(is_tail_out), 64'(t));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_send", 64'(send_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_dest", 64'(dest_out), 64'd0);
    chk("rst_tail", 64'(is_tail_out), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_flit", 64'(flit_count), 64'd0);
    chk("rst_count", 64'(dut.u_credit.count), 64'd2);
    chk("rst_ready", 64'(in_ready), 64'd0);

    // Credits exhaust after two accepts with no returns
    rst_n = 1'b1;
    drive(1'b1, 32'hA1, 3'd5, 1'b0, 1'b0);
    #1;
    chk("c_ready0", 64'(in_ready), 64'd1);
    tick();
    chk_flit("c_f1", 32'hA1, 3'd5, 1'b0);
    chk("c_ready1", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hA2, 3'd1, 1'b0, 1'b0);
    tick();
    chk_flit("c_f2", 32'hA2, 3'd5, 1'b0);
    chk("c_ready2", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hA3, 3'd1, 1'b0, 1'b0);
    tick();
    chk("c_nosend", 64'(send_out), 64'd0);
    chk("c_hold", 64'(data_out), 64'hA2);
    chk("c_count0", 64'(dut.u_credit.count), 64'd0);

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // 3-flit packet, credit returned every cycle
    drive(1'b1, 32'hB1, 3'd5, 1'b0, 1'b1);
    tick();
    chk_flit("p3_f1", 32'hB1, 3'd5, 1'b0);
    drive(1'b1, 32'hB2, 3'd1, 1'b0, 1'b1);
    tick();
    chk_flit("p3_f2", 32'hB2, 3'd5, 1'b0);
    drive(1'b1, 32'hB3, 3'd2, 1'b1, 1'b1);
    tick();
    chk_flit("p3_f3", 32'hB3, 3'd5, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("p3_idle", 64'(send_out), 64'd0);
    chk("p3_err", 64'(err_out), 64'd0);
    chk("p3_count", 64'(dut.u_credit.count), 64'd2);
    chk("p3_pkt", 64'(pkt_count), STATS ? 64'd1 : 64'd0);
    chk("p3_flit", 64'(flit_count), STATS ? 64'd3 : 64'd0);

    // Count=1 with simultaneous credit and accept
    drive(1'b1, 32'hC1, 3'd3, 1'b1, 1'b0);
    tick();
    chk_flit("k_f1", 32'hC1, 3'd3, 1'b1);
    chk("k_count1", 64'(dut.u_credit.count), 64'd1);
    drive(1'b1, 32'hC2, 3'd4, 1'b1, 1'b1);
    tick();
    chk_flit("k_f2", 32'hC2, 3'd4, 1'b1);
    chk("k_count_keep", 64'(dut.u_credit.count), 64'd1);
    chk("k_ready", 64'(in_ready), 64'd1);
    chk("k_err", 64'(err_out), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("k_count2", 64'(dut.u_credit.count), 64'd2);

    // 6-flit packet with MAX_PACKET_FLITS=4 is truncated at flit 4
    drive(1'b1, 32'hD1, 3'd6, 1'b0, 1'b1);
    tick();
    chk_flit("t_f1", 32'hD1, 3'd6, 1'b0);
    drive(1'b1, 32'hD2, 3'd1, 1'b0, 1'b1);
    tick();
    chk_flit("t_f2", 32'hD2, 3'd6, 1'b0);
    drive(1'b1, 32'hD3, 3'd2, 1'b0, 1'b1);
    tick();
    chk_flit("t_f3", 32'hD3, 3'd6, 1'b0);
    chk("t_err_pre", 64'(err_out), 64'd0);
    drive(1'b1, 32'hD4, 3'd3, 1'b0, 1'b1);
    tick();
    chk_flit("t_f4", 32'hD4, 3'd6, 1'b1);
    chk("t_err_trunc", 64'(err_out), 64'd2);
    drive(1'b1, 32'hD5, 3'd7, 1'b0, 1'b1);
    tick();
    chk_flit("t_f5", 32'hD5, 3'd7, 1'b0);
    drive(1'b1, 32'hD6, 3'd4, 1'b1, 1'b1);
    tick();
    chk_flit("t_f6", 32'hD6, 3'd7, 1'b1);
    chk("t_count", 64'(dut.u_credit.count), 64'd2);

    // Excess credit at full count saturates and sets the sticky flag
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("o_count", 64'(dut.u_credit.count), 64'd2);
    chk("o_err", 64'(err_out), 64'd3);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("o_sticky", 64'(err_out), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("o_clear", 64'(err_out), 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of a 4-flit packet
    drive(1'b1, 32'hE1, 3'd2, 1'b0, 1'b0);
    tick();
    chk_flit("r_f1", 32'hE1, 3'd2, 1'b0);
    drive(1'b1, 32'hE2, 3'd5, 1'b0, 1'b0);
    tick();
    chk_flit("r_f2", 32'hE2, 3'd2, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 32'hE3, 3'd5, 1'b0, 1'b0);
    tick();
    chk("r_send", 64'(send_out), 64'd0);
    chk("r_tail", 64'(is_tail_out), 64'd0);
    chk("r_count", 64'(dut.u_credit.count), 64'd2);
    rst_n = 1'b1;
    drive(1'b1, 32'hE4, 3'd6, 1'b0, 1'b0);
    tick();
    chk_flit("r_head", 32'hE4, 3'd6, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("r_idle", 64'(send_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_endpoint_tx.md
NOC_ENDPOINT_TX -- requirements
Module: noc_endpoint_tx

Interface
REQ-001 SHALL expose parameter FLIT_WIDTH, default 256, flit payload width in bits.
REQ-002 SHALL expose parameter DEST_WIDTH, default 3, destination endpoint ID width.
REQ-003 SHALL expose parameter FLIT_BUFFER_DEPTH, default 2, depth of the downstream router input buffer, which is also the initial credit count.
REQ-004 SHALL expose parameter MAX_PACKET_FLITS, default 16, maximum number of flits per packet, tail included.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock), then rst_n input 1 (synchronous, active-low reset).
REQ-006 in_valid  input  1  upstream flit valid.
REQ-007 in_ready  output  1  upstream flit accepted when high together with in_valid.
REQ-008 in_data  input  FLIT_WIDTH  upstream flit payload.
REQ-009 in_dest  input  DEST_WIDTH  destination; sampled on head flits only.
REQ-010 in_last  input  1  marks the last flit of a packet.
REQ-011 data_out  output  FLIT_WIDTH  flit payload sent to the router.
REQ-012 dest_out  output  DEST_WIDTH  packet destination, held constant for the whole packet.
REQ-013 is_tail_out  output  1  tail flit marker.
REQ-014 send_out  output  1  one-cycle pulse per flit transferred to the router.
REQ-015 credit_in  input  1  one-cycle pulse returning one router buffer slot.
REQ-016 err_out  output  2  sticky error flags: bit0 = credit overflow, bit1 = packet truncated.
REQ-017 pkt_count  output  32  packets sent (statistics).
REQ-018 flit_count  output  32  flits sent (statistics).

Function
REQ-019 The credit counter SHALL be $clog2(FLIT_BUFFER_DEPTH)+1 bits wide, reset to FLIT_BUFFER_DEPTH, and update each cycle as count + credit_in - accept, where accept = in_valid & in_ready.
REQ-020 in_ready SHALL equal (credit count != 0) & rst_n, combinationally, and SHALL NOT depend on in_valid.
REQ-021 An accept in cycle N SHALL produce send_out=1 in cycle N+1 with data_out, dest_out and is_tail_out registered from cycle N; if there is no accept, send_out SHALL be 0 and data_out/dest_out/is_tail_out SHALL hold their previous values.
REQ-022 Simultaneous credit_in and accept SHALL leave the counter unchanged; accepting the last credit together with credit_in SHALL keep in_ready high.
REQ-023 credit_in while the count equals FLIT_BUFFER_DEPTH and no accept occurs SHALL saturate the count and set err_out[0].
REQ-024 The FSM SHALL have states HEAD and BODY, with reset state HEAD.
REQ-025 An accept in HEAD SHALL latch in_dest as the packet destination; the state SHALL stay HEAD if in_last=1 (single-flit packet) and go to BODY otherwise.
REQ-026 An accept in BODY SHALL ignore in_dest and output the latched destination; in_last=1 SHALL return the FSM to HEAD.
REQ-027 A flit counter SHALL count accepted flits in the current packet. On the MAX_PACKET_FLITS-th flit with in_last=0, is_tail_out SHALL be forced to 1, err_out[1] SHALL be set, and the FSM SHALL return to HEAD; the next flit is a new head carrying its own in_dest.
REQ-028 is_tail_out SHALL equal the accepted in_last, OR the forced tail of REQ-027.

Reset
REQ-029 While rst_n=0, on the next clk edge: send_out=0, is_tail_out=0, data_out=0, dest_out=0, err_out=0, pkt_count=0, flit_count=0, credit count=FLIT_BUFFER_DEPTH, FSM=HEAD, flit counter=0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet without emitting a tail; the first accept after reset SHALL be treated as a head.

Configuration
REQ-031 Macro NOC_ENDPOINT_TX_STATS_EN defined: pkt_count SHALL increment on every send_out with is_tail_out=1, and flit_count on every send_out; both SHALL wrap modulo 2^32.
REQ-032 Macro NOC_ENDPOINT_TX_STATS_EN undefined: pkt_count and flit_count SHALL be constant 0, with no counter registers present; the port list SHALL be unchanged.

Structure
REQ-033 Package noc_pkg SHALL hold the FSM state enum (TX_HEAD, TX_BODY) and the err_out bit-index constants.
REQ-034 The credit counter SHALL be a sub-module named noc_credit_counter, with parameter DEPTH and ports clk, rst_n, credit_in, consume, count, overflow.

Verification
REQ-035 Reset, FLIT_BUFFER_DEPTH=2, no credit_in, in_valid held high -> exactly 2 accepts, send_out pulses in cycles 2 and 3 after reset release, then in_ready=0.
REQ-036 3-flit packet with in_dest=5 then 1 then 2, in_last on flit 3, credit_in returned every cycle -> dest_out=5 on all 3 flits, is_tail_out=1 only on flit 3, pkt_count=1, flit_count=3 (stats on).
REQ-037 Count=1 with credit_in and accept in the same cycle -> count stays 1, in_ready stays 1, err_out=0.
REQ-038 MAX_PACKET_FLITS=4, 6-flit packet with in_last only on flit 6 -> flit 4 has is_tail_out=1, err_out[1]=1, flits 5 and 6 form a new packet with dest taken from flit 5.
REQ-039 credit_in pulse at reset count of 2 -> count stays 2, err_out[0]=1 until the next reset.
REQ-040 rst_n low for 1 cycle after flit 2 of a 4-flit packet -> send_out=0 and count=2; the next accepted flit's in_dest appears on dest_out.
